// File: rtl/lane_pkt_drainer_if.sv
// Lane FIFO read port and framed output stream of the packet drainer.
// The master side is the drainer; the slave side is the FIFO plus the
// downstream arbiter/serializer.
interface lane_pkt_drainer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 4
) ();
   logic                  fifo_rd_en;
   logic                  fifo_rd_ack;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_empty;
   logic [CNT_WIDTH-1:0]  fifo_count;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_first;
   logic                  m_last;

   modport master (
      output fifo_rd_en,
      input  fifo_rd_ack, fifo_data, fifo_empty, fifo_count,
      output m_data, m_valid, m_first, m_last,
      input  m_ready
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_rd_ack, fifo_data, fifo_empty, fifo_count,
      input  m_data, m_valid, m_first, m_last,
      output m_ready
   );
endinterface

// File: rtl/lane_pkt_drainer.sv
// Lane packet drainer: pops words from the lane FIFO into a 3-entry skid
// buffer and emits them as one header beat followed by len payload beats.
// A packet starts when PKT_LEN words are buffered, or as a short packet
// once a partial fill has sat idle for TIMEOUT cycles.
module lane_pkt_drainer #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int PKT_LEN    = 4,
   parameter int LANE_ID    = 0,
   parameter int SEQ_WIDTH  = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   lane_pkt_drainer_if.master    bus,
   output logic                  busy,
   output logic [15:0]           pkt_count,
   output logic                  err_ack
);
   localparam int             CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1;
   localparam int             TW          = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0]  TIMER_LAST  = TW'(TIMEOUT - 1);
   localparam logic [7:0]     PKT_LEN_C   = 8'(PKT_LEN);
   localparam logic [3:0]     LANE_C      = 4'(LANE_ID);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   state_t                 state_r, state_nxt_s;
   logic [TW-1:0]          timer_r;
   logic [7:0]             len_r;
   logic [7:0]             issued_r;
   logic [7:0]             beat_r;
   logic [SEQ_WIDTH-1:0]   seq_r;
   logic [15:0]            pkt_count_r;
   logic                   err_ack_r;
   logic                   inflight_r;
   logic [DATA_WIDTH-1:0]  skid_r [3];
   logic [1:0]             wr_ptr_r, rd_ptr_r, occ_r;

   logic                   full_s, nonzero_s, timeout_s, start_s;
   logic                   rd_en_s, push_s, pop_s, last_beat_s, last_xfer_s;
   logic [DATA_WIDTH-1:0]  header_s;

   // Skid buffer pointers wrap modulo the three entries.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      case (p)
         2'd0:    ptr_inc = 2'd1;
         2'd1:    ptr_inc = 2'd2;
         default: ptr_inc = 2'd0;
      endcase
   endfunction

   assign full_s      = int'(bus.fifo_count) >= PKT_LEN;
   assign nonzero_s   = bus.fifo_count != {CNT_WIDTH{1'b0}};
   assign timeout_s   = nonzero_s && (timer_r == TIMER_LAST);
   assign start_s     = full_s || timeout_s;
   assign header_s    = DATA_WIDTH'({LANE_C, seq_r, len_r});
   // Read decision uses only registered state and the FIFO flag, never m_ready.
   assign rd_en_s     = (state_r != ST_IDLE) && (issued_r < len_r) && !bus.fifo_empty &&
                        (({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd3);
   assign push_s      = bus.fifo_rd_ack && inflight_r;
   assign pop_s       = (state_r == ST_PAYLOAD) && (occ_r != 2'd0) && bus.m_ready;
   assign last_beat_s = beat_r == (len_r - 8'd1);
   assign last_xfer_s = pop_s && last_beat_s;

   assign busy      = state_r != ST_IDLE;
   assign pkt_count = pkt_count_r;
   assign err_ack   = err_ack_r;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and stream/FIFO output decode from registered state.
   always_comb begin
      state_nxt_s    = state_r;
      bus.m_valid    = 1'b0;
      bus.m_first    = 1'b0;
      bus.m_last     = 1'b0;
      bus.m_data     = {DATA_WIDTH{1'b0}};
      bus.fifo_rd_en = rd_en_s;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_nxt_s = ST_HEADER;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HEADER: begin
            bus.m_valid = 1'b1;
            bus.m_first = 1'b1;
            bus.m_data  = header_s;
            if (bus.m_ready) begin
               state_nxt_s = ST_PAYLOAD;
            end else begin
               state_nxt_s = ST_HEADER;
            end
         end
         ST_PAYLOAD: begin
            if (occ_r != 2'd0) begin
               bus.m_valid = 1'b1;
               bus.m_data  = skid_r[rd_ptr_r];
               bus.m_last  = last_beat_s;
            end else begin
               bus.m_valid = 1'b0;
            end
            if (last_xfer_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_PAYLOAD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Packet bookkeeping: idle timer, length snapshot, read/beat counters, sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_r     <= {TW{1'b0}};
         len_r       <= 8'd0;
         issued_r    <= 8'd0;
         beat_r      <= 8'd0;
         seq_r       <= {SEQ_WIDTH{1'b0}};
         pkt_count_r <= 16'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  timer_r  <= {TW{1'b0}};
                  len_r    <= full_s ? PKT_LEN_C : 8'(bus.fifo_count);
                  issued_r <= 8'd0;
                  beat_r   <= 8'd0;
               end else if (nonzero_s) begin
                  timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
               end else begin
                  timer_r <= {TW{1'b0}};
               end
            end
            ST_HEADER, ST_PAYLOAD: begin
               if (rd_en_s) begin
                  issued_r <= issued_r + 8'd1;
               end
               if (pop_s) begin
                  beat_r <= beat_r + 8'd1;
               end
               if (last_xfer_s) begin
                  seq_r       <= seq_r + {{(SEQ_WIDTH-1){1'b0}}, 1'b1};
                  pkt_count_r <= pkt_count_r + 16'd1;
               end
            end
            default: begin
               timer_r <= {TW{1'b0}};
            end
         endcase
      end
   end

   // Read tracking, stray-ack flag and the 3-entry skid buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_r <= 1'b0;
         err_ack_r  <= 1'b0;
         wr_ptr_r   <= 2'd0;
         rd_ptr_r   <= 2'd0;
         occ_r      <= 2'd0;
         for (int i = 0; i < 3; i++) begin
            skid_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         inflight_r <= rd_en_s || (inflight_r && !bus.fifo_rd_ack);
         if (bus.fifo_rd_ack && !inflight_r) begin
            err_ack_r <= 1'b1;
         end
         if (push_s) begin
            skid_r[wr_ptr_r] <= bus.fifo_data;
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + 2'd1;
            2'b01:   occ_r <= occ_r - 2'd1;
            default: occ_r <= occ_r;
         endcase
      end
   end
endmodule

// File: tb/tb_lane_pkt_drainer.sv
// Self-checking bench for lane_pkt_drainer: a FIFO model with one-cycle
// read latency feeds the drainer, and expected beats are queued as words
// are pushed and compared as the stream transfers them.
module tb_lane_pkt_drainer;
   localparam int DW  = 32;
   localparam int FD  = 8;
   localparam int PL  = 4;
   localparam int LID = 3;
   localparam int SW  = 2;
   localparam int TO  = 16;
   localparam int CW  = $clog2(FD) + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [15:0] pkt_count;
   logic        err_ack;

   always #5 clk = ~clk;

   lane_pkt_drainer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   lane_pkt_drainer #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .PKT_LEN(PL),
      .LANE_ID(LID), .SEQ_WIDTH(SW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .busy(busy), .pkt_count(pkt_count), .err_ack(err_ack)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // FIFO model and stream sink state
   logic [DW-1:0]   fifo_q[$];
   logic [DW+1:0]   exp_q[$];
   bit              rd_seen  = 1'b0;
   bit              stray_req = 1'b0;
   bit              bp_mode  = 1'b0;
   int              cyc      = 0;
   int              seq_m    = 0;
   int              pkt_m    = 0;
   int              reads_done = 0;
   int              beats_done = 0;
   int              hdr_cyc  = -1;
   bit              stall_prev = 1'b0;
   logic [DW+1:0]   held;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) rd_seen = bus.fifo_rd_en;

   // FIFO read latency, stray-ack injection and m_ready pattern
   always @(posedge clk) begin
      #1;
      if (rd_seen && fifo_q.size() > 0) begin
         bus.fifo_data   = fifo_q.pop_front();
         bus.fifo_rd_ack = 1'b1;
      end else if (stray_req) begin
         bus.fifo_data   = 32'hDEAD_BEEF;
         bus.fifo_rd_ack = 1'b1;
         stray_req       = 1'b0;
      end else begin
         bus.fifo_data   = 32'h0000_0000;
         bus.fifo_rd_ack = 1'b0;
      end
      bus.fifo_count = CW'(fifo_q.size());
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.m_ready    = bp_mode ? ~bus.m_ready : 1'b1;
   end

   // Stream monitor: scoreboard compare, stall stability, read accounting
   always @(negedge clk) begin
      logic [DW+1:0] cur;
      logic [DW+1:0] exp_v;
      int            outstanding;
      if (rst) begin
         reads_done = 0;
         beats_done = 0;
         stall_prev = 1'b0;
      end else begin
         cur         = {bus.m_first, bus.m_last, bus.m_data};
         outstanding = reads_done - beats_done;
         if (busy) check_eq("occ_bound", 64'(outstanding <= 3), 64'd1);
         if (stall_prev) check_eq("hold", {bus.m_valid, cur}, {1'b1, held});
         if (bus.m_valid && bus.m_ready) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : {(DW+2){1'b1}};
            check_eq("beat", cur, exp_v);
            if (bus.m_first) hdr_cyc = cyc;
            else beats_done++;
            if (bus.m_last) begin
               pkt_m++;
               check_eq("drain_clean", {32'(outstanding), 31'd0, bus.fifo_rd_en}, {32'd1, 32'd0});
            end
         end
         stall_prev = bus.m_valid && !bus.m_ready;
         held       = cur;
         if (bus.fifo_rd_en) reads_done++;
      end
   end

   task automatic fifo_push(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      bus.fifo_count = CW'(fifo_q.size());
      bus.fifo_empty = 1'b0;
   endtask

   task automatic exp_hdr(input int len);
      logic [DW-1:0] h;
      h = DW'({4'(LID), SW'(seq_m), 8'(len)});
      exp_q.push_back({1'b1, 1'b0, h});
      seq_m = (seq_m + 1) % (1 << SW);
   endtask

   task automatic exp_beat(input logic [DW-1:0] w, input bit last);
      exp_q.push_back({1'b0, last, w});
   endtask

   // Full packet of PL words pushed at once; expectations queued alongside.
   task automatic full_pkt(input logic [DW-1:0] base);
      exp_hdr(PL);
      for (int i = 0; i < PL; i++) begin
         fifo_push(base * DW'(i + 1));
         exp_beat(base * DW'(i + 1), i == PL - 1);
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      check_eq(tag, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int b0;
      rst             = 1'b1;
      bus.fifo_rd_ack = 1'b0;
      bus.fifo_data   = 32'h0000_0000;
      bus.fifo_empty  = 1'b1;
      bus.fifo_count  = '0;
      bus.m_ready     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ctrl", {bus.m_valid, bus.m_first, bus.m_last, bus.fifo_rd_en, busy, err_ack}, 6'b0);
      check_eq("rst_data", bus.m_data, 32'h0);
      check_eq("rst_pkt_count", pkt_count, 16'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Full packet, header seq 0
      full_pkt(32'h11);
      wait_drain("drain_full", 100);
      check_eq("pkt_count_full", pkt_count, 16'(pkt_m));
      check_eq("busy_after_full", busy, 1'b0);

      // Timeout short packet of 2 words, then a late word for the next packet
      hdr_cyc = -1;
      fifo_push(32'hA5A5_0001);
      fifo_push(32'hA5A5_0002);
      t0 = cyc;
      exp_hdr(2);
      exp_beat(32'hA5A5_0001, 1'b0);
      exp_beat(32'hA5A5_0002, 1'b1);
      for (int i = 0; i < 100 && hdr_cyc < 0; i++) begin
         @(negedge clk);
         #1;
      end
      check_eq("timeout_latency", 64'(hdr_cyc - t0), 64'(TO));
      @(posedge clk);
      #1;
      fifo_push(32'hA5A5_0003);
      exp_hdr(1);
      exp_beat(32'hA5A5_0003, 1'b1);
      wait_drain("drain_short", 200);
      check_eq("pkt_count_short", pkt_count, 16'(pkt_m));

      // Backpressure: m_ready toggles every cycle
      bp_mode = 1'b1;
      full_pkt(32'h0101_0101);
      wait_drain("drain_bp", 200);
      bp_mode = 1'b0;
      check_eq("pkt_count_bp", pkt_count, 16'(pkt_m));

      // Fifth packet: sequence field wraps back to 0
      full_pkt(32'h77);
      wait_drain("drain_wrap", 100);

      // Reset in the middle of the payload after two words
      b0 = beats_done;
      full_pkt(32'h0BAD_0000 + 32'h1);
      for (int i = 0; i < 100 && (beats_done - b0) < 2; i++) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("rst_mid_ctrl", {bus.m_valid, bus.m_first, bus.m_last, bus.fifo_rd_en, busy}, 5'b0);
      check_eq("rst_mid_data", bus.m_data, 32'h0);
      check_eq("rst_mid_pkt_count", pkt_count, 16'h0);
      exp_q.delete();
      fifo_q.delete();
      seq_m = 0;
      pkt_m = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fresh packet after reset starts again at seq 0
      full_pkt(32'h21);
      wait_drain("drain_fresh", 100);
      check_eq("pkt_count_fresh", pkt_count, 16'(pkt_m));
      check_eq("no_err_after_rst", err_ack, 1'b0);

      // Stray acknowledge while idle
      stray_req = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("err_ack_set", err_ack, 1'b1);
      check_eq("stray_stream_idle", {bus.m_valid, busy}, 2'b00);
      full_pkt(32'h3C);
      wait_drain("drain_after_stray", 100);
      check_eq("err_ack_sticky", err_ack, 1'b1);
      check_eq("pkt_count_final", pkt_count, 16'(pkt_m));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
